// File: rtl/dmem_lsu_if.sv
// Core-side request/response and DataMem-side port bundle for dmem_lsu.
// slave = the LSU itself; master = the core plus DataMem that surround it.
interface dmem_lsu_if #(
  parameter int W = 8,
  parameter int A = 8
);
  logic         ReqValid;
  logic         ReqReady;
  logic [1:0]   ReqOp;
  logic [A-1:0] ReqAddr;
  logic [A-1:0] ReqSrcAddr;
  logic [W-1:0] ReqData;
  logic         RspValid;
  logic [W-1:0] RspData;
  logic         RspErr;
  logic         Busy;
  logic         MemReadEn;
  logic         MemWriteEn;
  logic [A-1:0] MemAddr;
  logic [W-1:0] MemDataIn;
  logic [W-1:0] MemDataOut;

  modport slave (
    input  ReqValid, ReqOp, ReqAddr, ReqSrcAddr, ReqData, MemDataOut,
    output ReqReady, RspValid, RspData, RspErr, Busy,
           MemReadEn, MemWriteEn, MemAddr, MemDataIn
  );

  modport master (
    output ReqValid, ReqOp, ReqAddr, ReqSrcAddr, ReqData, MemDataOut,
    input  ReqReady, RspValid, RspData, RspErr, Busy,
           MemReadEn, MemWriteEn, MemAddr, MemDataIn
  );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store/copy sequencer in front of single-port DataMem; load 3, store 2, copy 2*n+1 cycles to RspValid.
// One request in flight: ReqReady only in IDLE, ReqValid while busy is dropped, not queued.
module dmem_lsu #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  dmem_lsu_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, LD_RD, LD_CAP, ST_WR, CP_RD, CP_WR, DONE
  } state_t;

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_ST  = 2'b01;
  localparam logic [1:0] OP_CP  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef struct packed {
    logic [A-1:0] dst;
    logic [A-1:0] src;
    logic [W-1:0] dat;
  } req_t;

  state_t       state_q, state_d;
  req_t         req_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] rsp_dat_q;
  logic         rsp_err_q;

  logic         accept;
  logic [W:0]   cnt_inc;
  logic [A-1:0] cnt_ofs;

  logic         mem_rd;
  logic         mem_wr;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_din;

  assign accept  = (state_q == IDLE) && bus.ReqValid;
  assign cnt_inc = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};
  assign cnt_ofs = A'(cnt_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.ReqValid) begin
          case (bus.ReqOp)
            OP_LD:   state_d = LD_RD;
            OP_ST:   state_d = ST_WR;
            OP_CP:   state_d = (bus.ReqData != '0) ? CP_RD : DONE;
            default: state_d = DONE;
          endcase
        end
      end
      LD_RD:   state_d = LD_CAP;
      LD_CAP:  state_d = DONE;
      ST_WR:   state_d = DONE;
      CP_RD:   state_d = CP_WR;
      CP_WR:   state_d = (cnt_inc < {1'b0, req_q.dat}) ? CP_RD : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory strobes come only from registered state, so nothing on Req* reaches DataMem combinationally.
  always_comb begin
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    case (state_q)
      LD_RD: begin
        mem_rd   = 1'b1;
        mem_addr = req_q.dst;
      end
      ST_WR: begin
        mem_wr   = 1'b1;
        mem_addr = req_q.dst;
        mem_din  = req_q.dat;
      end
      CP_RD: begin
        mem_rd   = 1'b1;
        mem_addr = req_q.src + cnt_ofs;
      end
      CP_WR: begin
        mem_wr   = 1'b1;
        mem_addr = req_q.dst + cnt_ofs;
        mem_din  = bus.MemDataOut;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      cnt_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q <= '{dst: bus.ReqAddr, src: bus.ReqSrcAddr, dat: bus.ReqData};
        cnt_q <= '0;
      end
      if (state_q == CP_WR) begin
        cnt_q <= cnt_inc[W-1:0];
      end
      // Response fields change only on the way into DONE and then hold until the next one.
      if (state_q == LD_CAP) begin
        rsp_dat_q <= bus.MemDataOut;
        rsp_err_q <= 1'b0;
      end else if (state_d == DONE && state_q != DONE) begin
        rsp_dat_q <= '0;
        rsp_err_q <= accept && (bus.ReqOp == OP_RSV);
      end
    end
  end

  assign bus.ReqReady   = (state_q == IDLE);
  assign bus.Busy       = (state_q != IDLE);
  assign bus.RspValid   = (state_q == DONE);
  assign bus.RspData    = rsp_dat_q;
  assign bus.RspErr     = rsp_err_q;
  assign bus.MemReadEn  = mem_rd;
  assign bus.MemWriteEn = mem_wr;
  assign bus.MemAddr    = mem_addr;
  assign bus.MemDataIn  = mem_din;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: behavioural DataMem plus a reference memory image and per-op latency rules.
module tb_dmem_lsu;
  localparam int W = 8;
  localparam int A = 8;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  dmem_lsu_if #(.W(W), .A(A)) bus ();
  dmem_lsu #(.W(W), .A(A)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  // DataMem: registered read, synchronous write, plus a backdoor write port for preloading.
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] dout = 8'h00;
  logic       bd_we = 1'b0;
  logic [7:0] bd_addr = 8'h00;
  logic [7:0] bd_dat = 8'h00;

  always @(posedge Clk) begin
    if (bd_we) mem[bd_addr] <= bd_dat;
    else if (bus.MemWriteEn) mem[bus.MemAddr] <= bus.MemDataIn;
    if (bus.MemReadEn) dout <= mem[bus.MemAddr];
  end
  assign bus.MemDataOut = dout;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: the cycle after edge k is cycle k+1, and is seen here with cyc == k.
  int n_rd = 0, n_wr = 0, rsp_n = 0, rsp_cyc = 0, ready_n = 0, both_n = 0, busy_bad = 0;
  logic [7:0] rsp_dat = 8'h00;
  logic       rsp_err = 1'b0;
  int seq_q[$];

  always @(negedge Clk) begin
    if (!Reset) begin
      if (bus.MemReadEn) begin n_rd++; seq_q.push_back((cyc + 1) * 4 + 1); end
      if (bus.MemWriteEn) begin n_wr++; seq_q.push_back((cyc + 1) * 4 + 2); end
      if (bus.MemReadEn && bus.MemWriteEn) both_n++;
      if (bus.Busy !== !bus.ReqReady) busy_bad++;
      if (bus.ReqReady) ready_n++;
      if (bus.RspValid) begin
        rsp_n++;
        rsp_cyc = cyc + 1;
        rsp_dat = bus.RspData;
        rsp_err = bus.RspErr;
      end
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge Clk); #1;
    bd_we = 1'b1; bd_addr = a; bd_dat = d;
    @(posedge Clk); #1;
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] s,
                       input logic [7:0] d, input bit keep, output int acc);
    acc = -1;
    @(negedge Clk); #1;
    bus.ReqValid = 1'b1; bus.ReqOp = op; bus.ReqAddr = a; bus.ReqSrcAddr = s; bus.ReqData = d;
    for (int i = 0; i < 50; i++) begin
      if (bus.ReqReady) begin
        @(posedge Clk); #1;
        acc = cyc;
        break;
      end
      @(negedge Clk); #1;
    end
    if (!keep) bus.ReqValid = 1'b0;
  endtask

  task automatic wait_rsp(input int p0, input int budget, output int rc);
    rc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk); #1;
      if (rsp_n > p0) begin rc = rsp_cyc; return; end
    end
  endtask

  function automatic int ref_lat(input logic [1:0] op, input logic [7:0] cnt);
    case (op)
      2'b00:   return 3;
      2'b01:   return 2;
      2'b10:   return (cnt == 0) ? 1 : 2 * int'(cnt) + 1;
      default: return 1;
    endcase
  endfunction

  task automatic ref_copy(input logic [7:0] dst, input logic [7:0] src, input int n);
    logic [7:0] di, si;
    for (int i = 0; i < n; i++) begin
      di = dst + 8'(i);
      si = src + 8'(i);
      ref_mem[di] = ref_mem[si];
    end
  endtask

  task automatic test_reset();
    logic [31:0] got;
    for (int a = 0; a < 256; a++) poke(8'(a), 8'($urandom_range(0, 255)));
    @(negedge Clk); #1;
    got = {bus.ReqReady, bus.Busy, bus.RspValid, bus.RspErr, bus.MemReadEn, bus.MemWriteEn,
           bus.RspData, bus.MemAddr, bus.MemDataIn, 2'b00};
    checks++;
    if (got !== 32'h8000_0000) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", got, 32'h8000_0000); end
    Reset = 1'b0;
    @(negedge Clk); #1;
    checks++;
    if ({bus.ReqReady, bus.RspValid} !== 2'b10) begin
      failures++; $display("FAIL reset_release got=%b exp=10", {bus.ReqReady, bus.RspValid});
    end
  endtask

  task automatic test_load();
    int acc, rc, r0, w0, p0, q0, first_rd;
    poke(8'h10, 8'hA5);
    r0 = n_rd; w0 = n_wr; p0 = rsp_n; q0 = seq_q.size();
    issue(2'b00, 8'h10, 8'h00, 8'h00, 1'b0, acc);
    wait_rsp(p0, 20, rc);
    first_rd = (seq_q.size() > q0) ? seq_q[q0] : -1;
    checks++; if (first_rd != (acc + 1) * 4 + 1) begin failures++; $display("FAIL load_rd_cycle got=%0d exp=%0d", first_rd, (acc + 1) * 4 + 1); end
    checks++; if (n_rd - r0 != 1 || n_wr - w0 != 0) begin failures++; $display("FAIL load_mem_ops rd=%0d wr=%0d exp rd=1 wr=0", n_rd - r0, n_wr - w0); end
    checks++; if (rc != acc + 3) begin failures++; $display("FAIL load_latency got=%0d exp=%0d", rc, acc + 3); end
    checks++; if (rsp_dat !== ref_mem[8'h10] || rsp_err !== 1'b0) begin failures++; $display("FAIL load_data got=%h/%b exp=%h/0", rsp_dat, rsp_err, ref_mem[8'h10]); end
    @(negedge Clk); #1;
    checks++; if (bus.ReqReady !== 1'b1 || bus.RspValid !== 1'b0) begin failures++; $display("FAIL load_ready_after got=%b exp=10", {bus.ReqReady, bus.RspValid}); end
  endtask

  task automatic test_back_to_back();
    int acc, acc2, rc, rc2, r0, w0, p0, rdy0;
    r0 = n_rd; w0 = n_wr; p0 = rsp_n;
    issue(2'b01, 8'h80, 8'h00, 8'h3C, 1'b1, acc);
    rdy0 = ready_n;
    bus.ReqOp = 2'b00; bus.ReqData = 8'hC3;
    ref_mem[8'h80] = 8'h3C;
    wait_rsp(p0, 20, rc);
    checks++; if (rc != acc + 2) begin failures++; $display("FAIL store_latency got=%0d exp=%0d", rc, acc + 2); end
    checks++; if (n_wr - w0 != 1 || n_rd - r0 != 0) begin failures++; $display("FAIL store_mem_ops rd=%0d wr=%0d exp rd=0 wr=1", n_rd - r0, n_wr - w0); end
    checks++; if (ready_n != rdy0) begin failures++; $display("FAIL store_ready_busy got=%0d exp=%0d", ready_n - rdy0, 0); end
    checks++; if (rsp_dat !== 8'h00 || rsp_err !== 1'b0) begin failures++; $display("FAIL store_rsp got=%h/%b exp=00/0", rsp_dat, rsp_err); end
    p0 = rsp_n;
    issue(2'b00, 8'h80, 8'h00, 8'h00, 1'b0, acc2);
    wait_rsp(p0, 20, rc2);
    checks++; if (acc2 != acc + 3) begin failures++; $display("FAIL b2b_accept got=%0d exp=%0d", acc2, acc + 3); end
    checks++; if (rc2 != acc2 + 3 || rsp_dat !== ref_mem[8'h80]) begin failures++; $display("FAIL b2b_load got=%0d/%h exp=%0d/%h", rc2, rsp_dat, acc2 + 3, ref_mem[8'h80]); end
  endtask

  task automatic test_copy_wrap();
    int acc, rc, r0, w0, p0, q0, bad, ex;
    logic [7:0] v [4];
    logic [7:0] ix;
    v = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) poke(8'hFE + 8'(i), v[i]);
    r0 = n_rd; w0 = n_wr; p0 = rsp_n; q0 = seq_q.size();
    issue(2'b10, 8'h20, 8'hFE, 8'd4, 1'b0, acc);
    ref_copy(8'h20, 8'hFE, 4);
    wait_rsp(p0, 40, rc);
    checks++; if (rc != acc + 9) begin failures++; $display("FAIL copy_latency got=%0d exp=%0d", rc, acc + 9); end
    checks++; if (n_rd - r0 != 4 || n_wr - w0 != 4 || rsp_n - p0 != 1) begin failures++; $display("FAIL copy_counts rd=%0d wr=%0d rsp=%0d exp 4/4/1", n_rd - r0, n_wr - w0, rsp_n - p0); end
    bad = 0;
    for (int j = 0; j < 8; j++) begin
      ex = (acc + 1 + j) * 4 + ((j % 2 == 1) ? 2 : 1);
      if (q0 + j >= seq_q.size()) bad++;
      else if (seq_q[q0 + j] != ex) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL copy_alternation bad=%0d exp=0", bad); end
    for (int i = 0; i < 4; i++) begin
      ix = 8'h20 + 8'(i);
      checks++; if (mem[ix] !== v[i]) begin failures++; $display("FAIL copy_byte%0d got=%h exp=%h", i, mem[ix], v[i]); end
    end
    checks++; if (rsp_dat !== 8'h00 || rsp_err !== 1'b0) begin failures++; $display("FAIL copy_rsp got=%h/%b exp=00/0", rsp_dat, rsp_err); end
  endtask

  task automatic test_copy_zero();
    int acc, rc, r0, w0, p0;
    p0 = rsp_n;
    issue(2'b00, 8'h10, 8'h00, 8'h00, 1'b0, acc);
    wait_rsp(p0, 20, rc);
    r0 = n_rd; w0 = n_wr; p0 = rsp_n;
    issue(2'b10, 8'h50, 8'h30, 8'h00, 1'b0, acc);
    wait_rsp(p0, 20, rc);
    checks++; if (rc != acc + 1) begin failures++; $display("FAIL copy0_latency got=%0d exp=%0d", rc, acc + 1); end
    checks++; if (n_rd - r0 != 0 || n_wr - w0 != 0) begin failures++; $display("FAIL copy0_mem_ops rd=%0d wr=%0d exp 0/0", n_rd - r0, n_wr - w0); end
    checks++; if (rsp_dat !== 8'h00 || rsp_err !== 1'b0) begin failures++; $display("FAIL copy0_rsp got=%h/%b exp=00/0", rsp_dat, rsp_err); end
  endtask

  task automatic test_reserved();
    int acc, rc, r0, w0, p0;
    p0 = rsp_n;
    issue(2'b00, 8'h10, 8'h00, 8'h00, 1'b0, acc);
    wait_rsp(p0, 20, rc);
    r0 = n_rd; w0 = n_wr; p0 = rsp_n;
    issue(2'b11, 8'h44, 8'h55, 8'h66, 1'b0, acc);
    wait_rsp(p0, 20, rc);
    checks++; if (rc != acc + 1) begin failures++; $display("FAIL rsv_latency got=%0d exp=%0d", rc, acc + 1); end
    checks++; if (rsp_err !== 1'b1 || rsp_dat !== 8'h00) begin failures++; $display("FAIL rsv_rsp got=%h/%b exp=00/1", rsp_dat, rsp_err); end
    checks++; if (n_rd - r0 != 0 || n_wr - w0 != 0) begin failures++; $display("FAIL rsv_mem_ops rd=%0d wr=%0d exp 0/0", n_rd - r0, n_wr - w0); end
    p0 = rsp_n;
    issue(2'b00, 8'h80, 8'h00, 8'h00, 1'b0, acc);
    wait_rsp(p0, 20, rc);
    checks++; if (rsp_err !== 1'b0 || rsp_dat !== ref_mem[8'h80]) begin failures++; $display("FAIL rsv_next_load got=%h/%b exp=%h/0", rsp_dat, rsp_err, ref_mem[8'h80]); end
  endtask

  task automatic test_reset_mid_copy();
    int acc, rc, w0, p0;
    logic [31:0] got;
    logic [7:0] ix;
    for (int i = 0; i < 4; i++) begin
      poke(8'h40 + 8'(i), 8'h71 + 8'(i));
      poke(8'h60 + 8'(i), 8'hE0 + 8'(i));
    end
    w0 = n_wr; p0 = rsp_n;
    issue(2'b10, 8'h60, 8'h40, 8'd4, 1'b0, acc);
    for (int i = 0; i < 40 && (n_wr - w0) < 2; i++) begin @(negedge Clk); #1; end
    checks++; if (n_wr - w0 != 2) begin failures++; $display("FAIL rst_reach_wr2 got=%0d exp=2", n_wr - w0); end
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    @(negedge Clk); #1;
    got = {bus.ReqReady, bus.Busy, bus.RspValid, bus.RspErr, bus.MemReadEn, bus.MemWriteEn,
           bus.RspData, bus.MemAddr, bus.MemDataIn, 2'b00};
    checks++; if (got !== 32'h8000_0000) begin failures++; $display("FAIL rst_mid_outputs got=%h exp=%h", got, 32'h8000_0000); end
    Reset = 1'b0;
    repeat (3) begin @(negedge Clk); #1; end
    ref_copy(8'h60, 8'h40, 2);
    checks++; if (rsp_n != p0 || n_wr - w0 != 2) begin failures++; $display("FAIL rst_mid_activity rsp=%0d wr=%0d exp 0/2", rsp_n - p0, n_wr - w0); end
    for (int i = 0; i < 4; i++) begin
      ix = 8'h60 + 8'(i);
      checks++; if (mem[ix] !== ref_mem[ix]) begin failures++; $display("FAIL rst_mid_byte%0d got=%h exp=%h", i, mem[ix], ref_mem[ix]); end
    end
    p0 = rsp_n;
    issue(2'b00, 8'h61, 8'h00, 8'h00, 1'b0, acc);
    wait_rsp(p0, 20, rc);
    checks++; if (rc != acc + 3 || rsp_dat !== 8'h72) begin failures++; $display("FAIL rst_mid_load got=%0d/%h exp=%0d/72", rc, rsp_dat, acc + 3); end
  endtask

  task automatic test_random();
    int acc, rc, r0, w0, p0, lat, nrw, bad;
    logic [1:0] op;
    logic [7:0] a, s, d, exp_d;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = 8'hF8 + 8'($urandom_range(0, 15));
      s  = 8'hF8 + 8'($urandom_range(0, 15));
      d  = (op == 2'b10) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 255));
      lat = ref_lat(op, d);
      exp_d = 8'h00;
      nrw = 0;
      case (op)
        2'b00: exp_d = ref_mem[a];
        2'b01: ref_mem[a] = d;
        2'b10: begin ref_copy(a, s, int'(d)); nrw = int'(d); end
        default: ;
      endcase
      r0 = n_rd; w0 = n_wr; p0 = rsp_n;
      issue(op, a, s, d, 1'b0, acc);
      wait_rsp(p0, 40, rc);
      checks++; if (rc != acc + lat) begin failures++; $display("FAIL rnd%0d_latency op=%0d got=%0d exp=%0d", n, op, rc, acc + lat); end
      checks++; if (rsp_dat !== exp_d) begin failures++; $display("FAIL rnd%0d_data op=%0d got=%h exp=%h", n, op, rsp_dat, exp_d); end
      checks++; if (rsp_err !== (op == 2'b11)) begin failures++; $display("FAIL rnd%0d_err op=%0d got=%b exp=%b", n, op, rsp_err, op == 2'b11); end
      checks++;
      if (n_rd - r0 != ((op == 2'b00) ? 1 : nrw) || n_wr - w0 != ((op == 2'b01) ? 1 : nrw)) begin
        failures++; $display("FAIL rnd%0d_mem_ops op=%0d rd=%0d wr=%0d", n, op, n_rd - r0, n_wr - w0);
      end
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL rnd_mem_image bad=%0d exp=0", bad); end
  endtask

  initial begin
    bus.ReqValid = 1'b0; bus.ReqOp = 2'b00; bus.ReqAddr = 8'h00;
    bus.ReqSrcAddr = 8'h00; bus.ReqData = 8'h00;
    test_reset();
    test_load();
    test_back_to_back();
    test_copy_wrap();
    test_copy_zero();
    test_reserved();
    test_reset_mid_copy();
    test_random();
    checks++; if (both_n != 0) begin failures++; $display("FAIL rd_wr_overlap got=%0d exp=0", both_n); end
    checks++; if (busy_bad != 0) begin failures++; $display("FAIL busy_vs_ready got=%0d exp=0", busy_bad); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
